// File: rtl/mux16_rr_sched_if.sv
// rtl/mux16_rr_sched_if.sv - request/data/grant bundle for the 16-channel round-robin scheduler
interface mux16_rr_sched_if;
    logic [15:0] req;
    logic [15:0] in;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        busy;
    logic        out;

    modport master (
        output req,
        output in,
        input  sel,
        input  grant,
        input  busy,
        input  out
    );

    modport slave (
        input  req,
        input  in,
        output sel,
        output grant,
        output busy,
        output out
    );
endinterface

// File: rtl/mux16_rr_sched.sv
// rtl/mux16_rr_sched.sv - 16-channel round-robin grant scheduler with bounded hold and registered 16:1 mux
module mux16_rr_sched #(
    parameter int HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux16_rr_sched_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] RELOAD = 4'(HOLD - 1);

    state_t      state_q;
    logic [3:0]  sel_q;
    logic [15:0] grant_q;
    logic        busy_q;
    logic        out_q;
    logic [3:0]  cnt_q;
    logic [3:0]  last_q;

    logic [3:0]  win_d;
    logic        found_d;
    logic [3:0]  scan_idx;
    logic        any_req;
    logic        release_d;

    assign any_req = |bus.req;

    // Round-robin search: start just after the last winner, last winner itself is checked last
    always_comb begin
        win_d    = last_q;
        found_d  = 1'b0;
        scan_idx = last_q;
        for (int k = 1; k <= 16; k++) begin
            scan_idx = last_q + 4'(k);
            if (!found_d && bus.req[scan_idx]) begin
                win_d   = scan_idx;
                found_d = 1'b1;
            end
        end
    end

    // A new arbitration happens when idle, when the owner drops its request, or when its hold expires
    always_comb begin
        release_d = 1'b1;
        if (state_q == GRANT) begin
            release_d = !bus.req[sel_q] || (cnt_q == 4'd0);
        end
    end

    // Scheduler FSM with registered grant/select/busy and the one-cycle-late data mux
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 4'd0;
            grant_q <= 16'h0000;
            busy_q  <= 1'b0;
            out_q   <= 1'b0;
            cnt_q   <= 4'd0;
            last_q  <= 4'd15;
        end else begin
            out_q <= busy_q ? bus.in[sel_q] : 1'b0;
            if (release_d) begin
                if (any_req) begin
                    state_q <= GRANT;
                    sel_q   <= win_d;
                    grant_q <= 16'h0001 << win_d;
                    busy_q  <= 1'b1;
                    cnt_q   <= RELOAD;
                    last_q  <= win_d;
                end else begin
                    state_q <= IDLE;
                    grant_q <= 16'h0000;
                    busy_q  <= 1'b0;
                end
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign bus.sel   = sel_q;
    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.out   = out_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// tb/tb_mux16_rr_sched.sv - checks HOLD=4 and HOLD=1 schedulers against a cycle model plus directed vectors
module tb_mux16_rr_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = 16'h0000;
    logic [15:0] din = 16'h0000;

    int total = 0;
    int bad   = 0;

    mux16_rr_sched_if if4 ();
    mux16_rr_sched_if if1 ();

    assign if4.req = req;
    assign if4.in  = din;
    assign if1.req = req;
    assign if1.in  = din;

    mux16_rr_sched #(.HOLD(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
    mux16_rr_sched #(.HOLD(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    // model: index 0 is the HOLD=4 instance, index 1 the HOLD=1 instance
    int  m_hold [2] = '{4, 1};
    bit  m_busy [2];
    int  m_sel  [2];
    int  m_last [2];
    int  m_age  [2];
    bit  m_out  [2];
    bit  m_valid = 1'b0;

    function automatic int rr_pick(int last, logic [15:0] r);
        for (int k = 1; k <= 16; k++) begin
            if (r[(last + k) % 16]) return (last + k) % 16;
        end
        return -1;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] = 1'b0;
                m_sel[d]  = 0;
                m_last[d] = 15;
                m_age[d]  = 0;
                m_out[d]  = 1'b0;
            end else begin
                int w;
                m_out[d] = m_busy[d] ? din[m_sel[d]] : 1'b0;
                if (m_busy[d] && req[m_sel[d]] && m_age[d] < m_hold[d]) begin
                    m_age[d]++;
                end else begin
                    w = rr_pick(m_last[d], req);
                    if (w >= 0) begin
                        m_busy[d] = 1'b1;
                        m_sel[d]  = w;
                        m_last[d] = w;
                        m_age[d]  = 1;
                    end else begin
                        m_busy[d] = 1'b0;
                    end
                end
            end
        end
        if (rst) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_sel4",   int'(if4.sel),   m_sel[0]);
            chk("model_grant4", int'(if4.grant), m_busy[0] ? (1 << m_sel[0]) : 0);
            chk("model_busy4",  int'(if4.busy),  int'(m_busy[0]));
            chk("model_out4",   int'(if4.out),   int'(m_out[0]));
            chk("model_sel1",   int'(if1.sel),   m_sel[1]);
            chk("model_grant1", int'(if1.grant), m_busy[1] ? (1 << m_sel[1]) : 0);
            chk("model_busy1",  int'(if1.busy),  int'(m_busy[1]));
            chk("model_out1",   int'(if1.out),   int'(m_out[1]));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 16'h0000;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_grant", int'(if4.grant), 0);
        chk("rst_busy",  int'(if4.busy),  0);
        chk("rst_sel",   int'(if4.sel),   0);
        chk("rst_out",   int'(if4.out),   0);

        // single requester on channel 0 stays granted across reloads
        req = 16'h0001;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("solo_grant", int'(if4.grant), 16'h0001);
            chk("solo_sel",   int'(if4.sel),   0);
            chk("solo_busy",  int'(if4.busy),  1);
        end
        req = 16'h0000;
        tick();
        chk("solo_idle_busy",  int'(if4.busy),  0);
        chk("solo_idle_grant", int'(if4.grant), 0);

        // two requesters alternate every 4 cycles with no busy gap
        do_reset();
        req = 16'h8001;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("alt_sel",  int'(if4.sel),  ((k / 4) % 2) ? 15 : 0);
            chk("alt_busy", int'(if4.busy), 1);
        end
        req = 16'h0000;
        tick();

        // owner drops early; next grant gets a fresh full hold while later requests wait
        do_reset();
        req = 16'h0018;
        tick();
        chk("drop_sel3", int'(if4.sel), 3);
        tick();
        req = 16'h0010;
        tick();
        chk("drop_grant", int'(if4.grant), 16'h0010);
        chk("drop_sel4",  int'(if4.sel),   4);
        req = 16'h0030;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("drop_hold_sel", int'(if4.sel), 4);
        end
        tick();
        chk("drop_next_sel", int'(if4.sel), 5);
        req = 16'h0000;
        tick();

        // data path: out follows in[sel] one cycle later
        do_reset();
        din = 16'h30ab;
        req = 16'h0008;
        tick();
        chk("mux_sel3", int'(if4.sel), 3);
        tick();
        chk("mux_out3", int'(if4.out), 1);
        req = 16'h0004;
        tick();
        chk("mux_sel2", int'(if4.sel), 2);
        tick();
        chk("mux_out2", int'(if4.out), 0);
        req = 16'h0000;
        din = 16'h0000;
        tick();

        // reset in the middle of a grant aborts it and restarts priority at channel 0
        do_reset();
        req = 16'h0080;
        tick();
        chk("abort_sel7", int'(if4.sel), 7);
        tick();
        rst = 1'b1;
        tick();
        chk("abort_grant", int'(if4.grant), 0);
        chk("abort_busy",  int'(if4.busy),  0);
        chk("abort_out",   int'(if4.out),   0);
        chk("abort_sel",   int'(if4.sel),   0);
        rst = 1'b0;
        req = 16'hffff;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("abort_next_sel", int'(if4.sel), (k < 4) ? 0 : 1);
        end

        // HOLD=1 walks every channel once per cycle and wraps 15 -> 0
        do_reset();
        req = 16'hffff;
        for (int k = 0; k < 17; k++) begin
            tick();
            chk("h1_sel",  int'(if1.sel),  k % 16);
            chk("h1_busy", int'(if1.busy), 1);
        end
        req = 16'h0000;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
